// File: rtl/instr_fetch_unit_if.sv
// Bundle of load/control inputs and decoded fetch outputs for instr_fetch_unit.
// The fetch unit takes the slave side. A testbench or program loader takes the master side.
interface instr_fetch_unit_if #(
  parameter int DEPTH = 64
);
  localparam int AW = $clog2(DEPTH);

  logic          load_en;
  logic [AW-1:0] load_addr;
  logic [31:0]   load_data;
  logic          start;
  logic          stall;
  logic [31:0]   pc;
  logic [31:0]   instr;
  logic          valid;
  logic [6:0]    op;
  logic [2:0]    funct3;
  logic [6:0]    funct7;
  logic [4:0]    rd;
  logic [4:0]    rs1;
  logic [4:0]    rs2;
  logic          halted;
  logic [15:0]   retired;

  modport slave (
    input  load_en, load_addr, load_data, start, stall,
    output pc, instr, valid, op, funct3, funct7, rd, rs1, rs2, halted, retired
  );

  modport master (
    output load_en, load_addr, load_data, start, stall,
    input  pc, instr, valid, op, funct3, funct7, rd, rs1, rs2, halted, retired
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage of the single-cycle RISC-V core.
// It holds the PC, a word-addressed instruction memory and an IDLE/RUN/HALT sequencer.
// It slices the current instruction into the fields the control unit consumes.
module instr_fetch_unit #(
  parameter int DEPTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  instr_fetch_unit_if.slave     bus
);
  localparam int          AW    = $clog2(DEPTH);
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] ECALL = 32'h0000_0073;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t        state_q, state_d;
  // The PC is kept as a word index. Its byte-offset bits and its bits above AW+1 are constant zero.
  logic [AW-1:0] widx_q, widx_d;
  logic [15:0]   ret_q, ret_d;
  logic [31:0]   mem_q [DEPTH];
  logic [31:0]   rd_word;
  logic [15:0]   ret_inc;

  assign rd_word = mem_q[widx_q];
  assign ret_inc = (ret_q == 16'hFFFF) ? ret_q : ret_q + 16'd1;

  // Program load port: writes are accepted only while the core is not running.
  // The memory is never cleared by reset.
  always_ff @(posedge clk) begin
    if (bus.load_en && state_q != S_RUN)
      mem_q[bus.load_addr] <= bus.load_data;
  end

  // Sequencer, PC and retired-count registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      widx_q  <= '0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      widx_q  <= widx_d;
      ret_q   <= ret_d;
    end
  end

  // Next-state logic. An ECALL stops without retiring.
  // The last memory word retires, then halts in place rather than wrapping to 0.
  always_comb begin
    state_d = state_q;
    widx_d  = widx_q;
    ret_d   = ret_q;
    unique case (state_q)
      S_IDLE, S_HALT: begin
        if (bus.start) begin
          state_d = S_RUN;
          widx_d  = '0;
          ret_d   = '0;
        end
      end
      S_RUN: begin
        if (!bus.stall) begin
          if (rd_word == ECALL) begin
            state_d = S_HALT;
          end else if (widx_q == {AW{1'b1}}) begin
            ret_d   = ret_inc;
            state_d = S_HALT;
          end else begin
            widx_d  = widx_q + AW'(1);
            ret_d   = ret_inc;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Combinational outputs. The instruction is forced to NOP outside RUN,
  // so the decoded fields stay benign.
  always_comb begin
    bus.valid   = (state_q == S_RUN);
    bus.halted  = (state_q == S_HALT);
    bus.instr   = bus.valid ? rd_word : NOP;
    bus.pc      = {{(30-AW){1'b0}}, widx_q, 2'b00};
    bus.retired = ret_q;
    bus.op      = bus.instr[6:0];
    bus.rd      = bus.instr[11:7];
    bus.funct3  = bus.instr[14:12];
    bus.rs1     = bus.instr[19:15];
    bus.rs2     = bus.instr[24:20];
    bus.funct7  = bus.instr[31:25];
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit (DEPTH=64).
module tb_instr_fetch_unit;
  localparam int DEPTH = 64;

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;

  instr_fetch_unit_if #(.DEPTH(DEPTH)) bus ();
  instr_fetch_unit #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int a, input logic [31:0] d);
    bus.load_en = 1'b1; bus.load_addr = 6'(a); bus.load_data = d;
    step();
    bus.load_en = 1'b0;
  endtask

  task automatic go();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.load_en = 1'b0; bus.load_addr = '0; bus.load_data = '0;
    bus.start = 1'b0; bus.stall = 1'b0;
    #1;
    step(); step();
    chk("rst_pc", bus.pc, 32'd0);
    chk("rst_valid", 32'(bus.valid), 32'd0);
    chk("rst_halted", 32'(bus.halted), 32'd0);
    chk("rst_instr", bus.instr, 32'h13);
    chk("rst_op", 32'(bus.op), 32'h13);
    chk("rst_retired", 32'(bus.retired), 32'd0);
    rst = 1'b0;

    // Basic program: add, sub, ecall.
    load(0, 32'h002081B3);
    load(1, 32'h40118233);
    load(2, 32'h00000073);
    step();
    chk("idle_valid", 32'(bus.valid), 32'd0);
    go();
    chk("c1_valid", 32'(bus.valid), 32'd1);
    chk("c1_op", 32'(bus.op), 32'h33);
    chk("c1_f3", 32'(bus.funct3), 32'd0);
    chk("c1_f7", 32'(bus.funct7), 32'd0);
    chk("c1_rd", 32'(bus.rd), 32'd3);
    chk("c1_rs1", 32'(bus.rs1), 32'd1);
    chk("c1_rs2", 32'(bus.rs2), 32'd2);
    step();
    chk("c2_f7", 32'(bus.funct7), 32'h20);
    chk("c2_pc", bus.pc, 32'd4);
    chk("c2_rd", 32'(bus.rd), 32'd4);
    step();
    chk("c3_instr", bus.instr, 32'h73);
    step();
    chk("c4_halted", 32'(bus.halted), 32'd1);
    chk("c4_pc", bus.pc, 32'd8);
    chk("c4_retired", 32'(bus.retired), 32'd2);
    chk("c4_valid", 32'(bus.valid), 32'd0);
    chk("c4_instr", bus.instr, 32'h13);

    // Stall at pc=4 for three cycles.
    go();
    chk("restart_pc", bus.pc, 32'd0);
    chk("restart_halted", 32'(bus.halted), 32'd0);
    step();
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_pc", bus.pc, 32'd4);
      chk("stall_valid", 32'(bus.valid), 32'd1);
      chk("stall_retired", 32'(bus.retired), 32'd1);
    end
    bus.stall = 1'b0;
    step();
    chk("unstall_pc", bus.pc, 32'd8);
    chk("unstall_retired", 32'(bus.retired), 32'd2);
    step();
    chk("stall_halt", 32'(bus.halted), 32'd1);

    // A write attempted while running must be ignored.
    go();
    bus.load_en = 1'b1; bus.load_addr = 6'd1; bus.load_data = 32'hFFFFFFFF;
    step();
    bus.load_en = 1'b0;
    chk("runload_instr", bus.instr, 32'h40118233);
    step(); step();
    chk("runload_halt", 32'(bus.halted), 32'd1);

    // A write accepted in HALT is fetched after restart.
    load(1, 32'h00500093);
    chk("haltload_halted", 32'(bus.halted), 32'd1);
    go();
    step();
    chk("haltload_instr", bus.instr, 32'h00500093);
    chk("haltload_rd", 32'(bus.rd), 32'd1);
    chk("haltload_op", 32'(bus.op), 32'h13);
    step(); step();

    // End of memory: all NOPs, halt at the last word without wrapping.
    for (int a = 0; a < DEPTH; a++) load(a, 32'h13);
    go();
    for (int i = 0; i < DEPTH - 1; i++) step();
    chk("eom_pc_run", bus.pc, 32'd252);
    chk("eom_valid", 32'(bus.valid), 32'd1);
    step();
    chk("eom_halted", 32'(bus.halted), 32'd1);
    chk("eom_pc", bus.pc, 32'd252);
    chk("eom_retired", 32'(bus.retired), 32'd64);
    step();
    chk("eom_nowrap", bus.pc, 32'd252);

    // Reset mid-RUN at pc=12, then re-execute the program unchanged.
    load(0, 32'h002081B3);
    load(1, 32'h40118233);
    go();
    step(); step(); step();
    chk("mid_pc", bus.pc, 32'd12);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_pc", bus.pc, 32'd0);
    chk("mid_rst_valid", 32'(bus.valid), 32'd0);
    chk("mid_rst_halted", 32'(bus.halted), 32'd0);
    chk("mid_rst_retired", 32'(bus.retired), 32'd0);
    go();
    chk("rerun_w0", bus.instr, 32'h002081B3);
    step();
    chk("rerun_w1", bus.instr, 32'h40118233);
    chk("rerun_ret", 32'(bus.retired), 32'd1);

    // A load in the same cycle as start is visible on the first fetch.
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.load_en = 1'b1; bus.load_addr = 6'd0; bus.load_data = 32'h00000073;
    bus.start = 1'b1;
    step();
    bus.load_en = 1'b0; bus.start = 1'b0;
    chk("ldstart_instr", bus.instr, 32'h73);
    step();
    chk("ldstart_halted", 32'(bus.halted), 32'd1);
    chk("ldstart_pc", bus.pc, 32'd0);
    chk("ldstart_retired", 32'(bus.retired), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
